// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: FSM state encodings and datapath widths.
package i2c_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned IDLE_W  = 8;
    localparam int unsigned QTR_W   = 2;
    localparam int unsigned BIT_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_ADDR      = 4'd2,
        ST_ADDR_ACK  = 4'd3,
        ST_WRITE     = 4'd4,
        ST_WRITE_ACK = 4'd5,
        ST_READ      = 4'd6,
        ST_READ_NACK = 4'd7,
        ST_STOP      = 4'd8
    } state_e;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator for the I2C master.
// Ports: clk    - system clock
//        rst    - async active-low reset
//        tick_o - one-cycle pulse every CLK_DIV clk cycles (registered)
module i2c_clk_div
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Tick is registered from the next count so it lines up with the cycle
    // on which the counter wraps; CLK_DIV=1 ticks every cycle from reset.
    always_comb begin
        cnt_d  = (cnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : cnt_q + DIV_W'(1);
        tick_d = (cnt_d == DIV_W'(CLK_DIV - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= (CLK_DIV == 1);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/i2c_master.sv
// Free-running I2C master: repeatedly addresses SLAVE_ADDR and performs one
// byte write (rw=0) or one byte read (rw=1) per transaction.
// Ports: clk   - system clock
//        rst   - async active-low reset
//        rw    - direction, sampled when leaving IDLE
//        data  - write byte in (rw=0) / received byte out (rw latched 1)
//        state - current FSM state encoding
//        sclk  - push-pull SCL
//        sda   - open-drain SDA (drives 0 or Z)
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter logic [6:0]  SLAVE_ADDR    = 7'h50,
    parameter int unsigned IDLE_QUARTERS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rw,
    inout  wire  [BYTE_W-1:0]  data,
    output logic [STATE_W-1:0] state,
    output logic               sclk,
    inout  wire                sda
);

    logic              qtick;
    state_e            state_q, state_d;
    logic [QTR_W-1:0]  qcnt_q, qcnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0] wr_q, wr_d;
    logic [BYTE_W-1:0] rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              nack_q, nack_d;
    logic              sclk_q, sclk_d;
    logic              sda_low_q, sda_low_d;
    logic              byte_st;

    i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .tick_o (qtick)
    );

    assign byte_st = (state_q == ST_ADDR) || (state_q == ST_WRITE) || (state_q == ST_READ);

    // Bus registers hold the level of the quarter currently on the bus; each
    // tick computes the level of the quarter being entered.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        bit_d     = bit_q;
        idle_d    = idle_q;
        shift_d   = shift_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        rw_d      = rw_q;
        nack_d    = nack_q;
        sclk_d    = sclk_q;
        sda_low_d = sda_low_q;
        case (state_q)
            ST_IDLE: begin
                sclk_d    = 1'b1;
                sda_low_d = 1'b0;
                if (qtick) begin
                    if (idle_q == IDLE_W'(IDLE_QUARTERS - 1)) begin
                        state_d   = ST_START;
                        idle_d    = '0;
                        rw_d      = rw;
                        shift_d   = {SLAVE_ADDR, rw};
                        sda_low_d = 1'b1;
                        if (!rw) begin
                            wr_d = data;
                        end
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            ST_START: begin
                if (qtick) begin
                    state_d   = ST_ADDR;
                    qcnt_d    = '0;
                    bit_d     = 3'd7;
                    sclk_d    = 1'b0;
                    sda_low_d = ~shift_q[7];
                end
            end
            ST_ADDR, ST_ADDR_ACK, ST_WRITE, ST_WRITE_ACK, ST_READ, ST_READ_NACK: begin
                if (qtick) begin
                    qcnt_d = qcnt_q + QTR_W'(1);
                    if (qcnt_q == 2'd1) begin
                        // Entering q2: SCL rises, sample the line.
                        sclk_d = 1'b1;
                        if (state_q == ST_READ) begin
                            shift_d = {shift_q[6:0], sda};
                        end
                        if (state_q == ST_ADDR_ACK) begin
                            nack_d = sda;
                        end
                    end else if (qcnt_q == 2'd3) begin
                        // Entering q0 of the next bit: SCL falls, new SDA level.
                        sclk_d = 1'b0;
                        if (byte_st && (bit_q != 3'd0)) begin
                            bit_d = bit_q - 3'd1;
                            if (state_q != ST_READ) begin
                                shift_d   = {shift_q[6:0], 1'b0};
                                sda_low_d = ~shift_q[6];
                            end
                        end else begin
                            bit_d = 3'd7;
                            case (state_q)
                                ST_ADDR: begin
                                    state_d   = ST_ADDR_ACK;
                                    sda_low_d = 1'b0;
                                end
                                ST_ADDR_ACK: begin
                                    if (nack_q) begin
                                        state_d   = ST_STOP;
                                        sda_low_d = 1'b1;
                                    end else if (rw_q) begin
                                        state_d   = ST_READ;
                                        sda_low_d = 1'b0;
                                    end else begin
                                        state_d   = ST_WRITE;
                                        shift_d   = wr_q;
                                        sda_low_d = ~wr_q[7];
                                    end
                                end
                                ST_WRITE: begin
                                    state_d   = ST_WRITE_ACK;
                                    sda_low_d = 1'b0;
                                end
                                ST_READ: begin
                                    state_d   = ST_READ_NACK;
                                    rd_d      = shift_q;
                                    sda_low_d = 1'b0;
                                end
                                default: begin
                                    state_d   = ST_STOP;
                                    sda_low_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
            end
            ST_STOP: begin
                // q0: SCL low/SDA low, q1: SCL high, q2: SDA released -> IDLE.
                if (qtick) begin
                    qcnt_d = qcnt_q + QTR_W'(1);
                    case (qcnt_q)
                        2'd0: sclk_d = 1'b1;
                        2'd1: sda_low_d = 1'b0;
                        default: begin
                            state_d   = ST_IDLE;
                            qcnt_d    = '0;
                            sclk_d    = 1'b1;
                            sda_low_d = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
                state_d   = ST_IDLE;
                qcnt_d    = '0;
                idle_d    = '0;
                sclk_d    = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            qcnt_q    <= '0;
            bit_q     <= '0;
            idle_q    <= '0;
            shift_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            rw_q      <= 1'b0;
            nack_q    <= 1'b0;
            sclk_q    <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            bit_q     <= bit_d;
            idle_q    <= idle_d;
            shift_q   <= shift_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            rw_q      <= rw_d;
            nack_q    <= nack_d;
            sclk_q    <= sclk_d;
            sda_low_q <= sda_low_d;
        end
    end

    assign state = state_q;
    assign sclk  = sclk_q;
    assign sda   = sda_low_q ? 1'b0 : 1'bz;
    assign data  = rw_q ? rd_q : 8'hzz;

endmodule

// File: tb/tb_i2c_master.sv
// Directed self-checking bench for i2c_master with a simple slave model.
module tb_i2c_master;
    import i2c_pkg::*;

    logic       clk;
    logic       rst;
    logic       rw;
    logic       data_oe;
    logic [7:0] data_val;
    wire  [7:0] data;
    wire        sda;
    logic [3:0] state;
    logic       sclk;

    logic       slv_low;
    logic       ack_addr;
    logic [7:0] rd_byte;
    logic [2:0] rbit;

    logic        mon_clr;
    logic        prev_sclk, prev_sda;
    logic [3:0]  prev_state;
    logic [31:0] st_log, bit_log;
    int          st_n, bit_n, stop_n, viol_n, run_len, phase_n, phase_bad;

    int checks = 0;
    int errors = 0;

    assign data = data_oe ? data_val : 8'hzz;
    assign sda  = slv_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_master #(.CLK_DIV(4), .SLAVE_ADDR(7'h50), .IDLE_QUARTERS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .rw    (rw),
        .data  (data),
        .state (state),
        .sclk  (sclk),
        .sda   (sda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Bus monitor and slave model, sampled on the falling clk edge.
    initial begin
        st_log = 0; bit_log = 0; st_n = 0; bit_n = 0; stop_n = 0;
        viol_n = 0; run_len = 0; phase_n = 0; phase_bad = 0;
        prev_sclk = 1'b1; prev_sda = 1'b1; prev_state = 4'd0;
        slv_low = 1'b0; rbit = 3'd0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            slv_low <= 1'b0;
            rbit    <= 3'd0;
        end else begin
            if (mon_clr) begin
                st_log <= 0; st_n <= 0; bit_log <= 0; bit_n <= 0; stop_n <= 0;
            end else begin
                if (state != prev_state) begin
                    st_log <= {st_log[27:0], state};
                    st_n   <= st_n + 1;
                end
                if (!prev_sclk && sclk) begin
                    bit_log <= {bit_log[30:0], sda};
                    bit_n   <= bit_n + 1;
                end
                if (prev_sclk && sclk && !prev_sda && sda) stop_n <= stop_n + 1;
            end
            if (prev_sclk && sclk && (sda != prev_sda) && (state != 4'd1) && (state != 4'd8))
                viol_n <= viol_n + 1;
            if (sclk != prev_sclk) begin
                if (state == 4'd2 && prev_state == 4'd2) begin
                    phase_n <= phase_n + 1;
                    if (run_len != 8) phase_bad <= phase_bad + 1;
                end
                run_len <= 1;
            end else begin
                run_len <= run_len + 1;
            end
            // Slave updates SDA only just after SCL falls.
            if (prev_sclk && !sclk) begin
                if (state == 4'd3) begin
                    slv_low <= ack_addr;
                    rbit    <= 3'd0;
                end else if (state == 4'd5) begin
                    slv_low <= 1'b1;
                end else if (state == 4'd6) begin
                    slv_low <= ~rd_byte[3'd7 - rbit];
                    rbit    <= rbit + 3'd1;
                end else begin
                    slv_low <= 1'b0;
                    rbit    <= 3'd0;
                end
            end
        end
        prev_sclk  <= sclk;
        prev_sda   <= sda;
        prev_state <= state;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input bit eq, input string tag);
        int n = 0;
        while (((state == s) != eq) && (n < 4000)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 4000), 32'd1);
    endtask

    task automatic clr_logs();
        @(posedge clk) mon_clr = 1'b1;
        @(posedge clk) mon_clr = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; rw = 1'b0; data_oe = 1'b1; data_val = 8'hA5;
        ack_addr = 1'b1; rd_byte = 8'h3C; mon_clr = 1'b0;
        #3 rst = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_sda", 32'(sda), 32'd1);
        chk("rst_data", 32'(data), 32'hA5);

        // Write with ACK; rw/data changed mid-transaction must be ignored
        @(negedge clk) rst = 1'b1;
        clr_logs();
        wait_state(4'd2, 1'b1, "w_to_addr");
        rw = 1'b1; data_val = 8'h3F;
        wait_state(4'd0, 1'b1, "w_to_idle");
        rw = 1'b0;
        #1;
        chk("w_states", st_log, 32'h01234580);
        chk("w_bits", bit_log, 32'h00050294);
        chk("w_nbits", 32'(bit_n), 32'd19);
        chk("w_stop", 32'(stop_n), 32'd1);
        chk("w_data_z", 32'(data), 32'h3F);

        // Address NACK
        ack_addr = 1'b0;
        clr_logs();
        wait_state(4'd0, 1'b0, "n_leave_idle");
        wait_state(4'd0, 1'b1, "n_to_idle");
        #1;
        chk("n_states", st_log, 32'h00012380);
        chk("n_bits", bit_log, 32'h00000282);
        chk("n_nbits", 32'(bit_n), 32'd10);
        chk("n_stop", 32'(stop_n), 32'd1);

        // Read of 8'h3C
        data_oe = 1'b0; rw = 1'b1; ack_addr = 1'b1;
        clr_logs();
        wait_state(4'd0, 1'b0, "r_leave_idle");
        wait_state(4'd0, 1'b1, "r_to_idle");
        #1;
        chk("r_states", st_log, 32'h01236780);
        chk("r_bits", bit_log, 32'h000508F2);
        chk("r_nbits", 32'(bit_n), 32'd19);
        chk("r_stop", 32'(stop_n), 32'd1);
        chk("r_data", 32'(data), 32'h3C);

        // SCL phase widths and SDA stability over the three transactions
        chk("sda_stable", 32'(viol_n), 32'd0);
        chk("phase_bad", 32'(phase_bad), 32'd0);
        chk("phase_cnt", 32'(phase_n), 32'd45);

        // Reset during ADDR bit 3 (second quarter, SCL low)
        wait_state(4'd2, 1'b1, "x_to_addr");
        repeat (68) @(negedge clk);
        chk("x_pre_sclk", 32'(sclk), 32'd0);
        rst = 1'b0;
        #1;
        chk("x_state", 32'(state), 32'd0);
        chk("x_sclk", 32'(sclk), 32'd1);
        chk("x_sda", 32'(sda), 32'd1);
        rw = 1'b0; data_oe = 1'b1; data_val = 8'h96;
        #1;
        chk("x_data_z", 32'(data), 32'h96);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((state != 4'd1) && (n < 100));
        chk("x_start_lat", 32'(n), 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCL quarter-period (SCL period = 4*CLK_DIV clk); legal range 1..255.
REQ-002 Parameter SLAVE_ADDR, default 7'h50: 7-bit target address sent in every transaction.
REQ-003 Parameter IDLE_QUARTERS, default 4: minimum bus-free quarter-periods spent in IDLE between transactions.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-006 rw  input  1  transaction direction, 0=write, 1=read; sampled on IDLE->START.
REQ-007 data  inout  8  write byte (driven externally, rw=0) / read byte (driven by block, rw=1).
REQ-008 state  output  4  current FSM state encoding, for monitoring.
REQ-009 sclk  output  1  I2C clock, push-pull, high when bus idle.
REQ-010 sda  inout  1  I2C data, open-drain: block drives 0 or Z only, never 1.

Function
REQ-011 States and encodings SHALL be IDLE=0, START=1, ADDR=2, ADDR_ACK=3, WRITE=4, WRITE_ACK=5, READ=6, READ_NACK=7, STOP=8; 9..15 unused and SHALL go to IDLE.
REQ-012 A quarter-tick SHALL pulse once every CLK_DIV clk cycles; all bus activity SHALL advance only on quarter-ticks.
REQ-013 IDLE SHALL hold sclk=1, sda=Z, and after IDLE_QUARTERS ticks enter START, latching rw and, when rw=0, the data byte.
REQ-014 START SHALL pull sda low with sclk high for one quarter, then drive sclk low.
REQ-015 Each bit SHALL take 4 quarters: q0 sclk=0 and sda set up; q1 sclk=0; q2 sclk=1 and sda sampled; q3 sclk=1; bits MSB first.
REQ-016 ADDR SHALL send {SLAVE_ADDR, rw_latched}, 8 bits.
REQ-017 ADDR_ACK SHALL release sda and sample it at q2; 0=ACK goes to WRITE (rw=0) or READ (rw=1); 1=NACK goes to STOP.
REQ-018 WRITE SHALL send the latched byte; WRITE_ACK SHALL release sda for one bit and then enter STOP regardless of the ACK value.
REQ-019 READ SHALL release sda and shift in 8 bits, MSB first, sampled at q2; READ_NACK SHALL leave sda released (NACK) for one bit, then enter STOP.
REQ-020 STOP SHALL hold sda low with sclk low, raise sclk, then release sda while sclk is high, then return to IDLE.
REQ-021 After a successful read the received byte SHALL load a register that drives data while rw_latched=1; data SHALL be Z whenever rw_latched=0.
REQ-022 The block SHALL loop continuously through IDLE->transaction->STOP->IDLE with no external start signal.
REQ-023 sda SHALL change only while sclk=0, except during the START and STOP edges.
REQ-024 rw and data changes mid-transaction SHALL have no effect until the next START.

Reset
REQ-025 While rst=0: state=IDLE (0), sclk=1, sda=Z, data=Z, divider, bit counter, shift and read registers cleared to 0.
REQ-026 rst asserted mid-transaction SHALL immediately release sda and set sclk=1, with no STOP generated.
REQ-027 After rst deasserts, the first START SHALL occur IDLE_QUARTERS*CLK_DIV clk cycles later.

Structure
REQ-028 A shared package i2c_pkg SHALL hold the state enum and its 4-bit encodings; CLK_DIV and SLAVE_ADDR stay module parameters.
REQ-029 One sub-module, i2c_clk_div, SHALL generate the quarter-tick; the FSM, shifter and I/O buffers SHALL stay in i2c_master.

Verification
REQ-030 Write with ACK: rw=0, data=8'hA5, slave model ACKs both bytes -> SDA bits 1010000_0 then 10100101, state sequence 0,1,2,3,4,5,8,0.
REQ-031 Read: rw=1, slave ACKs the address and returns 8'h3C -> address byte 1010000_1, master NACKs, data=8'h3C after STOP.
REQ-032 Address NACK: slave leaves sda high -> state goes 3->8, no data phase, STOP seen (sda rises while sclk=1).
REQ-033 Timing: CLK_DIV=4 -> each SCL high and low phase = 8 clk cycles; sda never changes while sclk=1 outside START/STOP.
REQ-034 Reset mid-ADDR: rst=0 on bit 3 -> state=0, sclk=1, sda=Z within the same cycle; the next START comes 16 clk cycles after release.
